// File: rtl/nexys2_display_arbiter.sv
// nexys2_display_arbiter
// Shares the Nexys2 four-digit hex display between up to four requesters.
// Grant rotates round-robin with a programmable dwell time, and requester 0
// acts as an alert source that preempts on its rising edge. The selected
// source's value and decimal-point mask are driven out as registered nibbles.

module nexys2_display_arbiter #(
  parameter int unsigned DWELL = 12500000,
  parameter int unsigned CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [15:0]       data0,
  input  logic [15:0]       data1,
  input  logic [15:0]       data2,
  input  logic [15:0]       data3,
  input  logic [3:0]        dpi0,
  input  logic [3:0]        dpi1,
  input  logic [3:0]        dpi2,
  input  logic [3:0]        dpi3,
  output logic [3:0]        grant,
  output logic [3:0]        seg0,
  output logic [3:0]        seg1,
  output logic [3:0]        seg2,
  output logic [3:0]        seg3,
  output logic [3:0]        dp,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [1:0]       last_r;
  logic [1:0]       last_s;
  logic             req0_d_r;
  logic [1:0]       owner_s;
  logic [2:0]       pick_s;
  logic             rise0_s;
  logic             owned_s;
  logic [3:0]       grant_s;
  logic [15:0]      data_s;
  logic [3:0]       dpm_s;
  logic             busy_s;

  // Round-robin search: returns {found, index}; order is l+1, l+2, l+3, l.
  // Walking from the last candidate back to the first lets the earliest
  // requesting index in search order overwrite any later one.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] l);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = l + 2'(k);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // State, dwell counter, round-robin pointer and alert edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      last_r   <= 2'd3;
      req0_d_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      last_r   <= last_s;
      req0_d_r <= req[0];
    end
  end

  // Next-state logic: picks the owner for the coming cycle by event priority.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    owner_s = last_r;
    pick_s  = rr_search(req, last_r);
    rise0_s = req[0] & ~req0_d_r;
    owned_s = |(req & grant);
    case (state_r)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_s = ST_SHOW;
          cnt_s   = CNT_RELOAD;
          last_s  = pick_s[1:0];
          owner_s = pick_s[1:0];
        end else begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      ST_SHOW: begin
        if (rise0_s && (grant != 4'b0001)) begin
          // Alert source takes over immediately on its rising edge.
          state_s = ST_SHOW;
          cnt_s   = CNT_RELOAD;
          last_s  = 2'd0;
          owner_s = 2'd0;
        end else if (!owned_s) begin
          // Owner released: hand over directly, or go idle if nobody waits.
          if (pick_s[2]) begin
            state_s = ST_SHOW;
            cnt_s   = CNT_RELOAD;
            last_s  = pick_s[1:0];
            owner_s = pick_s[1:0];
          end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else if (cnt_r == CNT_ZERO) begin
          // Dwell over. The owner is still requesting, so the search always
          // finds someone: another source if one waits, else the owner again.
          state_s = ST_SHOW;
          cnt_s   = CNT_RELOAD;
          last_s  = pick_s[1:0];
          owner_s = pick_s[1:0];
        end else begin
          state_s = ST_SHOW;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        last_s  = 2'd3;
      end
    endcase
  end

  // Output decode: grant and display contents for the owner chosen above.
  always_comb begin
    grant_s = 4'b0000;
    data_s  = 16'h0000;
    dpm_s   = 4'b0000;
    busy_s  = 1'b0;
    if (state_s == ST_SHOW) begin
      grant_s = 4'b0001 << owner_s;
      busy_s  = 1'b1;
      case (owner_s)
        2'd0: begin data_s = data0; dpm_s = dpi0; end
        2'd1: begin data_s = data1; dpm_s = dpi1; end
        2'd2: begin data_s = data2; dpm_s = dpi2; end
        2'd3: begin data_s = data3; dpm_s = dpi3; end
        default: begin data_s = 16'h0000; dpm_s = 4'b0000; end
      endcase
    end else begin
      grant_s = 4'b0000;
      busy_s  = 1'b0;
    end
  end

  // Registered outputs so grant, digits, dp and busy all switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= 4'b0000;
      seg0  <= 4'h0;
      seg1  <= 4'h0;
      seg2  <= 4'h0;
      seg3  <= 4'h0;
      dp    <= 4'b0000;
      busy  <= 1'b0;
    end else begin
      grant <= grant_s;
      seg0  <= data_s[3:0];
      seg1  <= data_s[7:4];
      seg2  <= data_s[11:8];
      seg3  <= data_s[15:12];
      dp    <= dpm_s;
      busy  <= busy_s;
    end
  end

endmodule

// File: tb/tb_nexys2_display_arbiter.sv
// Directed bench for nexys2_display_arbiter with DWELL=4.
module tb_nexys2_display_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data0, data1, data2, data3;
  logic [3:0]  dpi0, dpi1, dpi2, dpi3;
  logic [3:0]  grant;
  logic [3:0]  seg0, seg1, seg2, seg3;
  logic [3:0]  dp;
  logic        busy;

  int errors = 0;
  int checks = 0;

  nexys2_display_arbiter #(.DWELL(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .dpi0(dpi0), .dpi1(dpi1), .dpi2(dpi2), .dpi3(dpi3),
    .grant(grant), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .dp(dp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; returns at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] outv();
    return {grant, seg3, seg2, seg1, seg0, dp, busy};
  endfunction

  function automatic logic [24:0] expv(input logic [3:0] g, input logic [15:0] d,
                                       input logic [3:0] m, input logic b);
    return {g, d, m, b};
  endfunction

  initial begin
    logic [3:0] rot_seq [4];
    rot_seq[0] = 4'b0010; rot_seq[1] = 4'b0100; rot_seq[2] = 4'b1000; rot_seq[3] = 4'b0010;

    data0 = 16'hA0A0; dpi0 = 4'b0001;
    data1 = 16'h1234; dpi1 = 4'b0011;
    data2 = 16'hBEEF; dpi2 = 4'b0010;
    data3 = 16'hC0DE; dpi3 = 4'b1000;

    // Reset with all requests high.
    rst = 1'b1; req = 4'b1111;
    tick(2);
    chk("reset_outputs", outv(), expv(4'b0000, 16'h0000, 4'b0000, 1'b0));
    rst = 1'b0;
    tick(1);
    chk("after_reset_grant0", outv(), expv(4'b0001, 16'hA0A0, 4'b0001, 1'b1));

    // Single request holds indefinitely, then drop to idle.
    rst = 1'b1; req = 4'b0100;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("single_grant", outv(), expv(4'b0100, 16'hBEEF, 4'b0010, 1'b1));
    tick(10);
    chk("single_hold", outv(), expv(4'b0100, 16'hBEEF, 4'b0010, 1'b1));
    req = 4'b0000;
    tick(1);
    chk("single_drop_idle", outv(), expv(4'b0000, 16'h0000, 4'b0000, 1'b0));

    // Rotation with three competing sources, 4 cycles each.
    rst = 1'b1; req = 4'b1110;
    tick(1);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1);
        chk($sformatf("rotate_g%0d_c%0d", g, c), {21'd0, grant}, {21'd0, rot_seq[g]});
      end
    end

    // Preempt by rising edge of req[0], then no re-preempt while held.
    rst = 1'b1; req = 4'b0100;
    tick(1);
    rst = 1'b0;
    tick(1);
    tick(1);
    chk("preempt_pre", {21'd0, grant}, {21'd0, 4'b0100});
    req = 4'b0101;
    tick(1);
    chk("preempt_take", outv(), expv(4'b0001, 16'hA0A0, 4'b0001, 1'b1));
    tick(3);
    chk("preempt_dwell", {21'd0, grant}, {21'd0, 4'b0001});
    tick(1);
    chk("preempt_rotate_back", outv(), expv(4'b0100, 16'hBEEF, 4'b0010, 1'b1));

    // Owner drop: direct handover, full dwell for the new owner.
    rst = 1'b1; req = 4'b0011;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("drop_initial", {21'd0, grant}, {21'd0, 4'b0001});
    tick(1);
    req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      chk($sformatf("drop_new_owner_c%0d", c), outv(), expv(4'b0010, 16'h1234, 4'b0011, 1'b1));
    end
    tick(1);
    chk("drop_then_rotate", {21'd0, grant}, {21'd0, 4'b0100});

    // Live data tracking and mid-dwell reset.
    rst = 1'b1; req = 4'b0010; data1 = 16'h1234;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("live_initial", outv(), expv(4'b0010, 16'h1234, 4'b0011, 1'b1));
    data1 = 16'h5678; dpi1 = 4'b0100;
    tick(1);
    chk("live_update", outv(), expv(4'b0010, 16'h5678, 4'b0100, 1'b1));
    rst = 1'b1;
    tick(1);
    chk("mid_dwell_reset", outv(), expv(4'b0000, 16'h0000, 4'b0000, 1'b0));
    rst = 1'b0;
    tick(1);
    chk("after_mid_reset", outv(), expv(4'b0010, 16'h5678, 4'b0100, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nexys2_display_arbiter.md
# nexys2_display_arbiter

Time-slicing arbiter that shares the Nexys2 four-digit hex display between up to four requesters (e.g. address, data, status and error sources in the programmer). Each cycle it selects one requester's 16-bit value and decimal-point mask and drives them as registered nibbles into the hex display driver's `seg0..seg3`/`dp` inputs. Grant rotates round-robin with a programmable dwell time. Requester 0 is an alert source that preempts on its rising edge.

## Interface
- `DWELL`, default 12500000: cycles a grant is held before rotating when another requester is pending; must be ≥ 2.
- `CNT_W`, default 24: dwell counter width; must hold `DWELL-1`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  level request per source; held high while the source wants the display.
- `data0..data3`  in  16 each  display value per source; [3:0] → digit 0 (rightmost), [15:12] → digit 3.
- `dpi0..dpi3`  in  4 each  decimal-point mask per source; bit i lights digit i.
- `grant`  out  4  one-hot current owner; 0000 when idle.
- `seg0..seg3`  out  4 each  nibbles to hex driver.
- `dp`  out  4  decimal-point mask to hex driver.
- `busy`  out  1  high in SHOW state.

## Operation
- State machine:
  - IDLE: `grant`=0000, `seg0..seg3`=0, `dp`=0.
  - SHOW: `grant` one-hot, dwell counter `cnt` running.
- Round-robin pointer `last` (2 bits) holds the index of the most recent grant. Search order is `last+1, last+2, last+3, last` (mod 4). The first requesting index in that order wins. `last` updates on every new grant.
- IDLE → SHOW: any `req` bit high. Winner chosen by the search. `cnt` ← `DWELL-1`.
- In SHOW, each cycle: `seg*`/`dp` ← granted source's live `data`/`dpi` (registered copy, tracks changes). `cnt` decrements while non-zero.
- Priority of SHOW events, highest first:
  1. Preempt: rising edge of `req[0]` (`req[0]` & ~`req0_d`) while grant ≠ 0001 → grant 0001, `cnt` reload, `last`=0.
  2. Owner drop: granted `req` bit low → next winner by search if any request pending (`cnt` reload), else IDLE.
  3. Expiry: `cnt`==0 → if another source is requesting, rotate to search winner (`cnt` reload). Else, if owner still requesting, stay and reload `cnt`.
- A held-high `req[0]` does not re-preempt. Source 0 then competes in round-robin like the others.
- `req0_d` is a register of `req[0]`, cleared by reset. A `req[0]` already high when leaving reset counts as a rising edge.
- Search excludes nothing. When the owner is the only requester at expiry, it wins again.
- `busy` = (state == SHOW).

## Timing
- All outputs are registered. `grant`, `seg*`, `dp` and `busy` change on the same edge.
- Request latency: `req` sampled high at edge N in IDLE → `grant` and the source's data visible after edge N.
- Data latency: a change on the owner's `data`/`dpi` appears on `seg*`/`dp` one cycle later.
- Dwell: with competing requests, each grant lasts exactly `DWELL` cycles.
- Preempt latency: 1 cycle from the `req[0]` rising edge.
- Owner-drop latency: 1 cycle. Handover is direct source-to-source with no IDLE cycle between grants.
- `rst` high at any edge, including mid-dwell → next cycle:
  - state IDLE, `grant`=0000, `seg0..seg3`=0, `dp`=0, `busy`=0.
  - `cnt`=0, `last`=3 (first search starts at 0), `req0_d`=0.

## Test plan
(`DWELL`=4)
- Reset: hold `rst` 2 cycles with `req`=1111 → `grant`=0000, `seg*`=0, `dp`=0, `busy`=0. First cycle after release: `grant`=0001.
- Single request: `req`=0100, `data2`=16'hBEEF, `dpi2`=4'b0010 → next cycle `grant`=0100, `seg3..0`=B,E,E,F, `dp`=0010. Holds indefinitely. Drop `req` → IDLE next cycle, outputs 0.
- Rotation: `req`=1110 from reset → `grant` sequence 0010, 0100, 1000, 0010, each held exactly 4 cycles.
- Preempt: `grant`=0100 at `cnt`=2, raise `req[0]` → next cycle `grant`=0001. Keep `req`=0101 → after 4 cycles `grant`=0100 (no re-preempt).
- Owner drop: `req`=0011, `grant`=0001, drop `req[0]` mid-dwell → next cycle `grant`=0010, no IDLE cycle, full 4-cycle dwell.
- Live tracking and mid-operation reset: change `data1` from 1234 to 5678 while granted → `seg*` shows 5678 one cycle later. Assert `rst` mid-dwell → all outputs 0 next cycle.
